img_pool_buf: RTL and testbench
===============================

// Module: img_pool_buf
// PURPOSE
//  Consumes the 112x112 8-bit pixel stream produced by the simulation/image source stage (vsync, bin_data_vld, bin_data).
//  Average-pools each 4x4 pixel block into one pixel and stores the resulting 28x28 image in an internal frame buffer.
//  Signals frame completion and exposes a random-access read port so the CNN first layer can fetch the image.
// PARAMETERS
//  IN_W        112  valid pixels per input line
//  IN_H        112  valid lines per input frame
//  SCALE_LOG2  2    log2 of pooling factor (4x4 blocks); OUT_W=IN_W>>SCALE_LOG2, OUT_H=IN_H>>SCALE_LOG2
//  DW          8    pixel width
// PORTS
//  sclk          in   1   system clock
//  s_rst_n       in   1   asynchronous active-low reset
//  vsync         in   1   one-cycle frame-start pulse
//  bin_data_vld  in   1   pixel qualifier; bin_data sampled when high
//  bin_data      in   DW  input pixel
//  rd_addr       in   10  buffer read address, row-major (row*OUT_W+col), 0..783
//  rd_data       out  DW  buffer read data, 1-cycle latency
//  frame_done    out  1   one-cycle pulse when last pooled pixel is written
//  frame_rdy     out  1   level: buffer holds a complete frame
//  ovf_err       out  1   sticky: valid pixel received after frame full
// BEHAVIOUR
//  Reset: all counters 0; frame_done=0, frame_rdy=0, ovf_err=0, rd_data=0; buffer contents undefined.
//  Counters: col_in 0..IN_W-1 advances per valid pixel; wraps to 0 and increments row_in. row_in saturates at IN_H (frame full).
//  vsync: clears col_in, row_in, frame_rdy, ovf_err; partial pooled data discarded. vsync has priority over a same-cycle
//   valid pixel; that pixel is dropped. Mid-frame vsync restarts the frame; no frame_done for the aborted frame.
//  Line accumulators: OUT_W entries, 12 bits each (16*255=4080 fits). blk_col = col_in>>SCALE_LOG2.
//   Pixel with row_in[1:0]==0 && col_in[1:0]==0: acc[blk_col] <= bin_data (load, not add).
//   Other pixels: acc[blk_col] <= acc[blk_col] + bin_data.
//   Pixel with row_in[1:0]==3 && col_in[1:0]==3: write (acc[blk_col]+bin_data)>>4 (truncate) to
//   buffer address (row_in>>2)*OUT_W + blk_col in the same cycle; accumulator need not be updated.
//  Frame end: write to address OUT_W*OUT_H-1 -> frame_done=1 next cycle for exactly 1 cycle, frame_rdy=1 same cycle,
//   held until next vsync or reset.
//  Valid pixel while row_in==IN_H (and no vsync): ignored, no buffer write, ovf_err<=1.
//  Input without preceding vsync after reset: accepted as frame starting at (0,0).
//  Buffer: simple dual-port, 784 x DW, one write port (pooling), one read port. rd_data <= mem[rd_addr] every cycle,
//   no enable. Read and write same address same cycle: rd_data returns old contents.
//   Reading before frame_rdy is legal; data is stale/partial. rd_addr >= 784: rd_data unspecified, no side effects.
//  Reset mid-frame: all state cleared as above; next frame needs no special handling.
//  Throughput: one pixel per cycle sustained; gaps in bin_data_vld of any length allowed.
// TESTING
//  1 Reset, vsync, 12544 valid pixels all 200 -> frame_done pulse 1 cycle after last pixel; all 784 reads return 200.
//  2 Each 4x4 block filled with (block_index mod 256) -> rd_addr=k returns k mod 256; rd_addr=783 returns 15 after 1 cycle.
//  3 Block 0: 8 pixels 255, 8 pixels 0 -> mem[0]=127; block 1: pixels 0..15 -> sum 120, mem[1]=7 (truncation).
//  4 vsync after 50 rows of frame A, then full frame B of 100s -> no frame_done for A; one pulse for B; all reads 100.
//  5 Full frame then 5 extra valid pixels of 0 -> ovf_err=1, buffer unchanged, frame_rdy stays 1; next vsync clears both.
//  6 Assert s_rst_n=0 mid-frame (row 60) -> all outputs 0 asynchronously; subsequent vsync + full frame of 50 reads 50.

Source files
------------

// File: rtl/img_pool_buf.sv
// 4x4 average-pooling frame buffer: reduces a 112x112 pixel stream to a 28x28 image
// and serves it to the next stage through a registered random-access read port.
module img_pool_buf #(
  parameter int IN_W       = 112,
  parameter int IN_H       = 112,
  parameter int SCALE_LOG2 = 2,
  parameter int DW         = 8
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  input  logic          vsync,
  input  logic          bin_data_vld,
  input  logic [DW-1:0] bin_data,
  input  logic [9:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          frame_done,
  output logic          frame_rdy,
  output logic          ovf_err
);

  localparam int OUT_W = IN_W >> SCALE_LOG2;
  localparam int OUT_H = IN_H >> SCALE_LOG2;
  localparam int DEPTH = OUT_W * OUT_H;
  localparam int AW    = 10;
  localparam int CW    = $clog2(IN_W);
  localparam int RW    = $clog2(IN_H + 1);
  localparam int BW    = CW - SCALE_LOG2;
  localparam int ACC_W = DW + 2 * SCALE_LOG2;

  logic [CW-1:0]    col_in_reg;
  logic [RW-1:0]    row_in_reg;
  logic [ACC_W-1:0] acc_mem [OUT_W];
  logic [DW-1:0]    buf_mem [DEPTH];

  logic             frame_full;
  logic             pix_acc;
  logic             blk_first;
  logic             blk_last;
  logic             wr_en;
  logic [BW-1:0]    blk_col;
  logic [ACC_W-1:0] acc_sum;
  logic [AW-1:0]    wr_addr;

  assign frame_full = (row_in_reg == RW'(IN_H));
  assign pix_acc    = bin_data_vld && !vsync && !frame_full;
  assign blk_col    = col_in_reg[CW-1:SCALE_LOG2];
  assign blk_first  = (row_in_reg[SCALE_LOG2-1:0] == '0) && (col_in_reg[SCALE_LOG2-1:0] == '0);
  assign blk_last   = (&row_in_reg[SCALE_LOG2-1:0]) && (&col_in_reg[SCALE_LOG2-1:0]);
  assign acc_sum    = acc_mem[blk_col] + ACC_W'(bin_data);
  assign wr_en      = pix_acc && blk_last;
  assign wr_addr    = AW'(row_in_reg[RW-1:SCALE_LOG2]) * AW'(OUT_W) + AW'(blk_col);

  // Position counters and status flags; vsync wins over a same-cycle pixel.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      col_in_reg <= '0;
      row_in_reg <= '0;
      frame_done <= 1'b0;
      frame_rdy  <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (vsync) begin
        col_in_reg <= '0;
        row_in_reg <= '0;
        frame_rdy  <= 1'b0;
        ovf_err    <= 1'b0;
      end else if (bin_data_vld) begin
        if (frame_full) begin
          ovf_err <= 1'b1;
        end else begin
          if (col_in_reg == CW'(IN_W - 1)) begin
            col_in_reg <= '0;
            row_in_reg <= row_in_reg + 1'b1;
          end else begin
            col_in_reg <= col_in_reg + 1'b1;
          end
          if (wr_en && (wr_addr == AW'(DEPTH - 1))) begin
            frame_done <= 1'b1;
            frame_rdy  <= 1'b1;
          end
        end
      end
    end
  end

  // The first pixel of a block reloads its accumulator, so stale sums never need clearing.
  always_ff @(posedge sclk) begin
    if (pix_acc) begin
      acc_mem[blk_col] <= blk_first ? ACC_W'(bin_data) : acc_sum;
    end
  end

  always_ff @(posedge sclk) begin
    if (wr_en) begin
      buf_mem[wr_addr] <= acc_sum[ACC_W-1:2*SCALE_LOG2];
    end
  end

  // Read-before-write: a same-address write is seen on the following read.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      rd_data <= '0;
    end else if (rd_addr < AW'(DEPTH)) begin
      rd_data <= buf_mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_img_pool_buf.sv
// Randomised stream bench for img_pool_buf with an image-level pooling model and per-cycle compare.
`timescale 1ns/1ps
module tb_img_pool_buf;

  localparam int IN_W  = 112;
  localparam int IN_H  = 112;
  localparam int OUT_W = 28;
  localparam int OUT_H = 28;
  localparam int NPIX  = IN_W * IN_H;
  localparam int DEPTH = OUT_W * OUT_H;

  logic       sclk = 1'b0;
  logic       s_rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       bin_data_vld = 1'b0;
  logic [7:0] bin_data = 8'd0;
  logic [9:0] rd_addr = 10'd0;
  logic [7:0] rd_data;
  logic       frame_done;
  logic       frame_rdy;
  logic       ovf_err;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  img_pool_buf #(.IN_W(IN_W), .IN_H(IN_H), .SCALE_LOG2(2), .DW(8)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n), .vsync(vsync), .bin_data_vld(bin_data_vld),
    .bin_data(bin_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_done(frame_done), .frame_rdy(frame_rdy), .ovf_err(ovf_err)
  );

  always #5 sclk = ~sclk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: keeps the accepted image and averages each 4x4 block once its last pixel lands.
  int         n_acc = 0;
  logic [7:0] img   [NPIX];
  logic [7:0] mmem  [DEPTH];
  bit         mvalid[DEPTH];
  bit         exp_done = 0, exp_rdy = 0, exp_ovf = 0, exp_rd_ok = 1;
  logic [7:0] exp_rd = 8'd0;
  int         m_r, m_c, m_s, m_a;

  always @(negedge s_rst_n) begin
    n_acc = 0; exp_done = 0; exp_rdy = 0; exp_ovf = 0;
    exp_rd = 8'd0; exp_rd_ok = 1;
    foreach (mvalid[i]) mvalid[i] = 0;
  end

  always @(posedge sclk) begin
    if (s_rst_n) begin
      exp_done = 0;
      if (rd_addr < 10'(DEPTH)) begin
        exp_rd_ok = mvalid[rd_addr];
        exp_rd    = mmem[rd_addr];
      end else begin
        exp_rd_ok = 0;
      end
      if (vsync) begin
        n_acc = 0; exp_rdy = 0; exp_ovf = 0;
      end else if (bin_data_vld) begin
        if (n_acc == NPIX) begin
          exp_ovf = 1;
        end else begin
          m_r = n_acc / IN_W;
          m_c = n_acc % IN_W;
          img[n_acc] = bin_data;
          n_acc++;
          if ((m_r % 4 == 3) && (m_c % 4 == 3)) begin
            m_s = 0;
            for (int i = 0; i < 4; i++)
              for (int j = 0; j < 4; j++)
                m_s += int'(img[(m_r - 3 + i) * IN_W + (m_c - 3 + j)]);
            m_a = (m_r / 4) * OUT_W + (m_c / 4);
            mmem[m_a]   = 8'(m_s / 16);
            mvalid[m_a] = 1;
            if (m_a == DEPTH - 1) begin
              exp_done = 1;
              exp_rdy  = 1;
            end
          end
        end
      end
    end
  end

  always @(posedge sclk) begin
    #2;
    chk("frame_done", int'(frame_done), int'(exp_done));
    chk("frame_rdy", int'(frame_rdy), int'(exp_rdy));
    chk("ovf_err", int'(ovf_err), int'(exp_ovf));
    if (exp_rd_ok) chk("rd_data", int'(rd_data), int'(exp_rd));
    if (frame_done) done_cnt++;
  end

  task automatic drive(input bit vs, input bit vl, input logic [7:0] d);
    @(negedge sclk);
    vsync = vs; bin_data_vld = vl; bin_data = d;
    rd_addr = 10'($urandom_range(0, 799));
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic pixel(input logic [7:0] d);
    if ($urandom_range(0, 31) == 0) idle($urandom_range(1, 3));
    drive(1'b0, 1'b1, d);
  endtask

  // The pixel sharing the vsync cycle is randomly valid and must be dropped.
  task automatic start_frame();
    drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic send_rows(input int mode, input int val, input int rows);
    int r, c;
    logic [7:0] d;
    for (int n = 0; n < rows * IN_W; n++) begin
      r = n / IN_W;
      c = n % IN_W;
      case (mode)
        0: d = 8'(val);
        1: d = 8'(((r / 4) * OUT_W + (c / 4)) % 256);
        2: begin
          if (r < 4 && c < 4)      d = (r < 2) ? 8'd255 : 8'd0;
          else if (r < 4 && c < 8) d = 8'((r % 4) * 4 + (c % 4));
          else                     d = 8'($urandom);
        end
        default: d = 8'($urandom);
      endcase
      pixel(d);
    end
  endtask

  task automatic read_lit(input int a, input int lit, input string nm);
    @(negedge sclk);
    vsync = 1'b0; bin_data_vld = 1'b0; rd_addr = 10'(a);
    @(negedge sclk);
    chk(nm, int'(rd_data), lit);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    repeat (3) @(negedge sclk);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_frame_rdy", int'(frame_rdy), 0);
    chk("reset_ovf_err", int'(ovf_err), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    s_rst_n = 1'b1;

    start_frame();
    send_rows(0, 200, IN_H);
    @(negedge sclk);
    bin_data_vld = 1'b0;
    chk("t1_done_pulse", int'(frame_done), 1);
    chk("t1_rdy", int'(frame_rdy), 1);
    @(negedge sclk);
    chk("t1_done_single", int'(frame_done), 0);
    for (int a = 0; a < DEPTH; a++) read_lit(a, 200, "t1_read");
    $display("test 1: flat frame of 200 read back");

    start_frame();
    send_rows(1, 0, IN_H);
    idle(2);
    read_lit(783, 15, "t2_read_783");
    read_lit(300, 44, "t2_read_300");
    for (int a = 0; a < DEPTH; a += 13) read_lit(a, a % 256, "t2_read");
    $display("test 2: block-index frame read back");

    d0 = done_cnt;
    for (int i = 0; i < 5; i++) pixel(8'd0);
    idle(1);
    chk("t5_ovf", int'(ovf_err), 1);
    chk("t5_rdy_kept", int'(frame_rdy), 1);
    read_lit(783, 15, "t5_unchanged_783");
    read_lit(27, 27, "t5_unchanged_27");
    start_frame();
    idle(1);
    chk("t5_ovf_cleared", int'(ovf_err), 0);
    chk("t5_rdy_cleared", int'(frame_rdy), 0);
    $display("test 5: overflow flagged and cleared by vsync");

    send_rows(2, 0, 50);
    idle(2);
    read_lit(0, 127, "t3_block0");
    read_lit(1, 7, "t3_block1");
    $display("test 3: truncating averages checked");

    start_frame();
    send_rows(0, 100, IN_H);
    idle(2);
    chk("t4_done_count", done_cnt - d0, 1);
    for (int a = 0; a < DEPTH; a++) read_lit(a, 100, "t4_read");
    $display("test 4: aborted frame A, frame B of 100 read back");

    start_frame();
    send_rows(3, 0, 60);
    @(posedge sclk);
    #3;
    s_rst_n = 1'b0;
    #1;
    chk("t6_rst_rd_data", int'(rd_data), 0);
    chk("t6_rst_frame_done", int'(frame_done), 0);
    chk("t6_rst_frame_rdy", int'(frame_rdy), 0);
    chk("t6_rst_ovf_err", int'(ovf_err), 0);
    @(negedge sclk);
    vsync = 1'b0; bin_data_vld = 1'b0;
    @(negedge sclk);
    s_rst_n = 1'b1;
    start_frame();
    send_rows(0, 50, IN_H);
    idle(2);
    chk("t6_rdy", int'(frame_rdy), 1);
    for (int a = 0; a < DEPTH; a++) read_lit(a, 50, "t6_read");
    $display("test 6: mid-frame reset then frame of 50 read back");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
